link_rx_demux: RTL and testbench
================================

Name: link_rx_demux

Overview:
- Receive-side endpoint of the muxed link stream.
- Splits the tagged link word stream into a non-blocking event stream and a backpressured config stream.
- The link cannot be stalled, so config words are buffered in an internal FIFO; overflow is detected, dropped and counted.
- Sits between the link deserializer output and the event router / config consumer.

Parameters:
- DATA_W, 64, payload width of one link word
- DEPTH, 8, config FIFO depth in words; power of two, min 2
- CNT_W, 16, width of the saturating drop counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- link_valid  in  1  muxed link word valid; no ready, never stalled
- link_ty  in  1  word type: 0 = EVENT, 1 = DATA (config)
- link_data  in  DATA_W  muxed payload
- ev_valid  out  1  event output valid, non-blocking, single-cycle pulse per word
- ev_data  out  DATA_W  event payload
- cfg_valid  out  1  config output valid
- cfg_ready  in  1  config consumer ready
- cfg_data  out  DATA_W  config payload
- cfg_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky, set on first dropped config word
- drop_cnt  out  CNT_W  number of dropped config words, saturating
- clr_status  in  1  synchronous clear of overflow and drop_cnt
- credit  out  1  credit return pulse (see Optional Feature)

Behaviour:
- Reset, asynchronous, active-low:
  - all outputs are 0; FIFO is empty; pointers are 0.
  - ev_data and cfg_data are 0.
- Event path:
  - link_valid && link_ty==0 registers into ev_valid/ev_data; latency 1 cycle.
  - ev_valid is high for exactly one cycle per word; no backpressure.
  - ev_data holds its last value when ev_valid is low.
- Config path:
  - push = link_valid && link_ty==1.
  - pop = cfg_valid && cfg_ready.
  - cfg_valid = FIFO not empty; cfg_data = FIFO head.
  - Standard valid/ready: cfg_data is stable while cfg_valid && !cfg_ready.
- Latency:
  - A word pushed into an empty FIFO is visible on cfg_valid/cfg_data the next cycle.
  - No same-cycle fallthrough.
- Pointers:
  - Read and write pointers are log2(DEPTH)+1 bits and wrap naturally.
  - full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal.
- cfg_level is the registered occupancy; it updates the cycle after push/pop.
- Full boundary:
  - push while full and no pop in the same cycle: word is dropped, overflow is set, drop_cnt increments.
  - push while full and pop in the same cycle: push is accepted and level is unchanged.
- Empty boundary:
  - a pop request while empty is impossible (cfg_valid=0).
  - push and pop in the same cycle at level 1 leaves level 1 with the new word at the head.
- drop_cnt saturates at 2^CNT_W-1 and does not wrap.
- clr_status:
  - clears overflow and drop_cnt on the next edge.
  - A drop in the same cycle as clr_status wins: overflow=1 and drop_cnt=1.
- Reset mid-operation discards all FIFO contents; any in-flight event pulse is lost.

Optional Feature:
- Macro: LINK_RX_CREDIT_EN.
- Defined:
  - credit pulses high for 1 cycle, one cycle after each accepted pop.
  - The transmitter starts with DEPTH credits; with credit-respecting transmitters, overflow never occurs.
- Undefined:
  - credit is tied to 0 and no credit logic is synthesized.

Test Plan:
- Event word 0xA5 with link_ty=0 -> ev_valid high for 1 cycle, 1 cycle later, ev_data=0xA5; cfg_valid stays 0.
- 3 config words 1,2,3 back-to-back, cfg_ready=1 -> cfg_data 1,2,3 on consecutive cycles starting 1 cycle after the first push; cfg_level peaks at 1.
- cfg_ready=0, push DEPTH+2 config words (DEPTH=8) -> cfg_level=8, overflow=1, drop_cnt=2; draining returns the first 8 words in order.
- FIFO full, cfg_ready=1 and push in the same cycle -> no drop, level stays 8, drop_cnt unchanged.
- Interleaved event/config words, cfg_ready toggling every cycle, 1000 random words -> every event appears after exactly 1 cycle; config order is preserved; no loss while level < DEPTH.
- drop_cnt at max with CNT_W=4, i.e. 15, then another drop -> drop_cnt stays 15.
- clr_status with a simultaneous drop -> overflow=1, drop_cnt=1.
- Assert rst_n mid-drain -> outputs are 0 immediately.
- With LINK_RX_CREDIT_EN defined: each pop gives exactly one credit pulse 1 cycle later, 5 pops -> 5 pulses.

Source files
------------

// File: rtl/link_rx_demux.sv
// Receive endpoint of the muxed link: splits tagged words into a registered event pulse
// stream and a FIFO-buffered config stream. Optional credit return via LINK_RX_CREDIT_EN.
module link_rx_demux #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      link_valid,
    input  logic                      link_ty,
    input  logic [DATA_W-1:0]         link_data,
    output logic                      ev_valid,
    output logic [DATA_W-1:0]         ev_data,
    output logic                      cfg_valid,
    input  logic                      cfg_ready,
    output logic [DATA_W-1:0]         cfg_data,
    output logic [$clog2(DEPTH):0]    cfg_level,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_cnt,
    input  logic                      clr_status,
    output logic                      credit
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  level_q, level_d;
    logic              cfg_valid_q, cfg_valid_d;
    logic [DATA_W-1:0] cfg_data_q, cfg_data_d;
    logic              ev_valid_q, ev_valid_d;
    logic [DATA_W-1:0] ev_data_q, ev_data_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic full_c;
    logic push_c;
    logic pop_c;
    logic push_acc_c;
    logic drop_c;

    // Next-state for pointers, head register, status and event path
    always_comb begin
        full_c     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push_c     = link_valid && link_ty;
        pop_c      = cfg_valid_q && cfg_ready;
        push_acc_c = push_c && (!full_c || pop_c);
        drop_c     = push_c && full_c && !pop_c;

        wr_ptr_d    = wr_ptr_q + PTR_W'(push_acc_c);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
        level_d     = wr_ptr_d - rd_ptr_d;
        cfg_valid_d = (wr_ptr_d != rd_ptr_d);

        // The incoming word becomes the head when it lands in the slot the read pointer moves to
        if (push_acc_c && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            cfg_data_d = link_data;
        end else begin
            cfg_data_d = mem[rd_ptr_d[AW-1:0]];
        end

        ev_valid_d = link_valid && !link_ty;
        ev_data_d  = ev_valid_d ? link_data : ev_data_q;

        overflow_d = clr_status ? 1'b0 : overflow_q;
        drop_cnt_d = clr_status ? '0 : drop_cnt_q;
        // A drop coincident with a clear restarts the count at one
        if (drop_c) begin
            overflow_d = 1'b1;
            if (clr_status) begin
                drop_cnt_d = CNT_W'(1);
            end else if (drop_cnt_q != {CNT_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cfg_valid_q <= 1'b0;
            cfg_data_q  <= '0;
            ev_valid_q  <= 1'b0;
            ev_data_q   <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_data_q  <= cfg_data_d;
            ev_valid_q  <= ev_valid_d;
            ev_data_q   <= ev_data_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage needs no reset: contents are only observed behind valid pointers
    always_ff @(posedge clk) begin
        if (push_acc_c) begin
            mem[wr_ptr_q[AW-1:0]] <= link_data;
        end
    end

`ifdef LINK_RX_CREDIT_EN
    logic credit_q, credit_d;

    always_comb begin
        credit_d = pop_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= 1'b0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit = credit_q;
`else
    assign credit = 1'b0;
`endif

    assign ev_valid  = ev_valid_q;
    assign ev_data   = ev_data_q;
    assign cfg_valid = cfg_valid_q;
    assign cfg_data  = cfg_data_q;
    assign cfg_level = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_link_rx_demux.sv
// Self-checking bench for link_rx_demux: vector table for the basic paths, then a
// scoreboard-driven model for overflow, random traffic, saturation, credit and reset.
module tb_link_rx_demux;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = 15;

    logic              clk;
    logic              rst_n;
    logic              link_valid;
    logic              link_ty;
    logic [DATA_W-1:0] link_data;
    logic              ev_valid;
    logic [DATA_W-1:0] ev_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_data;
    logic [3:0]        cfg_level;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;
    logic              clr_status;
    logic              credit;

    link_rx_demux #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .link_valid (link_valid),
        .link_ty    (link_ty),
        .link_data  (link_data),
        .ev_valid   (ev_valid),
        .ev_data    (ev_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .cfg_level  (cfg_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .clr_status (clr_status),
        .credit     (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] cfg_q[$];
    logic [DATA_W-1:0] ev_q[$];
    logic [DATA_W-1:0] last_ev;
    logic              m_ovf;
    int                m_cnt;
    logic              exp_credit;

    typedef struct {
        logic              v;
        logic              ty;
        logic [DATA_W-1:0] d;
        logic              rdy;
        logic              e_ev_valid;
        logic [DATA_W-1:0] e_ev_data;
        logic              e_cfg_valid;
        logic              chk_data;
        logic [DATA_W-1:0] e_cfg_data;
        logic [3:0]        e_level;
    } vec_t;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        link_valid = 1'b0;
        link_ty    = 1'b0;
        link_data  = '0;
        clr_status = 1'b0;
    endtask

    // One cycle of stimulus with the scoreboard updated alongside
    task automatic drive(input logic v, input logic ty, input logic [DATA_W-1:0] d,
                         input logic rdy, input logic clr);
        logic pop, push, drop;
        logic [DATA_W-1:0] tmp;
        pop  = (cfg_q.size() != 0) && rdy;
        push = v && ty;
        drop = push && (cfg_q.size() == DEPTH) && !pop;
        link_valid = v;
        link_ty    = ty;
        link_data  = d;
        cfg_ready  = rdy;
        clr_status = clr;
        if (v && !ty) ev_q.push_back(d);
        @(posedge clk);
        if (pop) tmp = cfg_q.pop_front();
        if (push && !drop) cfg_q.push_back(d);
        if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (drop) begin
            m_ovf = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1);
        end
`ifdef LINK_RX_CREDIT_EN
        exp_credit = pop;
`else
        exp_credit = 1'b0;
`endif
        #1;
        set_idle();
        chk("ev_valid", ev_valid, (ev_q.size() != 0));
        if (ev_q.size() != 0) last_ev = ev_q.pop_front();
        chk("ev_data", ev_data, last_ev);
        chk("cfg_valid", cfg_valid, (cfg_q.size() != 0));
        if (cfg_q.size() != 0) chk("cfg_data", cfg_data, cfg_q[0]);
        chk("cfg_level", cfg_level, cfg_q.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_cnt);
        chk("credit", credit, exp_credit);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ev_valid"},  ev_valid,  0);
        chk({tag, "_ev_data"},   ev_data,   0);
        chk({tag, "_cfg_valid"}, cfg_valid, 0);
        chk({tag, "_cfg_data"},  cfg_data,  0);
        chk({tag, "_cfg_level"}, cfg_level, 0);
        chk({tag, "_overflow"},  overflow,  0);
        chk({tag, "_drop_cnt"},  drop_cnt,  0);
        chk({tag, "_credit"},    credit,    0);
    endtask

    initial begin
        vec_t vecs[5];
        int   pulses;

        rst_n     = 1'b0;
        cfg_ready = 1'b0;
        set_idle();
        cfg_q.delete();
        ev_q.delete();
        last_ev    = '0;
        m_ovf      = 1'b0;
        m_cnt      = 0;
        exp_credit = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 64'hA5, 1'b1, 1'b1, 64'hA5, 1'b0, 1'b0, 64'h0, 4'd0};
        vecs[1] = '{1'b1, 1'b1, 64'h1,  1'b1, 1'b0, 64'hA5, 1'b1, 1'b1, 64'h1, 4'd1};
        vecs[2] = '{1'b1, 1'b1, 64'h2,  1'b1, 1'b0, 64'hA5, 1'b1, 1'b1, 64'h2, 4'd1};
        vecs[3] = '{1'b1, 1'b1, 64'h3,  1'b1, 1'b0, 64'hA5, 1'b1, 1'b1, 64'h3, 4'd1};
        vecs[4] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'hA5, 1'b0, 1'b0, 64'h0, 4'd0};

        #22;
        chk_all_zero("reset");
        rst_n = 1'b1;
        #1;

        // Event pulse and back-to-back config words through an empty FIFO
        for (int i = 0; i < 5; i++) begin
            link_valid = vecs[i].v;
            link_ty    = vecs[i].ty;
            link_data  = vecs[i].d;
            cfg_ready  = vecs[i].rdy;
            @(posedge clk);
            #1;
            set_idle();
            chk($sformatf("vec%0d_ev_valid", i),  ev_valid,  vecs[i].e_ev_valid);
            chk($sformatf("vec%0d_ev_data", i),   ev_data,   vecs[i].e_ev_data);
            chk($sformatf("vec%0d_cfg_valid", i), cfg_valid, vecs[i].e_cfg_valid);
            if (vecs[i].chk_data) chk($sformatf("vec%0d_cfg_data", i), cfg_data, vecs[i].e_cfg_data);
            chk($sformatf("vec%0d_cfg_level", i), cfg_level, vecs[i].e_level);
        end
        last_ev = 64'hA5;

        // Overflow: DEPTH+2 pushes with the consumer stalled
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, 1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
        chk("ovf_level", cfg_level, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop_cnt", drop_cnt, 2);
        chk("ovf_head", cfg_data, 64'h100);

        // Full with simultaneous pop and push: accepted, no drop
        drive(1'b1, 1'b1, 64'h200, 1'b1, 1'b0);
        chk("fullpp_level", cfg_level, 8);
        chk("fullpp_drop_cnt", drop_cnt, 2);
        chk("fullpp_head", cfg_data, 64'h101);
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Random interleaved traffic, consumer ready toggling every cycle
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'(i % 2), 1'b0);
        end
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Counter saturation
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("clr_overflow", overflow, 0);
        chk("clr_drop_cnt", drop_cnt, 0);
        for (int i = 0; i < DEPTH + 17; i++) drive(1'b1, 1'b1, 64'h300 + 64'(i), 1'b0, 1'b0);
        chk("sat_drop_cnt", drop_cnt, 15);

        // Clear coincident with a drop
        drive(1'b1, 1'b1, 64'h400, 1'b0, 1'b1);
        chk("clrdrop_overflow", overflow, 1);
        chk("clrdrop_drop_cnt", drop_cnt, 1);

        // Five pops, credit pulses counted
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, '0, (i < 5), 1'b0);
            if (credit) pulses++;
        end
`ifdef LINK_RX_CREDIT_EN
        chk("credit_pulses", pulses, 5);
`else
        chk("credit_pulses", pulses, 0);
`endif

        // Reset mid-drain with an event pulse in flight
        drive(1'b1, 1'b0, 64'h77, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_all_zero("midrst");
        #1;
        rst_n = 1'b1;
        cfg_q.delete();
        ev_q.delete();
        last_ev = '0;
        m_ovf   = 1'b0;
        m_cnt   = 0;
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 64'h55, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
